// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the single-port memory arbiter.
// Sequencer states, access-type encodings and the round-robin pointer wrap.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    // Index of the requester just after idx, wrapping at n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Rotate-priority encoder: first set request bit scanning upward from rr_ptr,
// wrapping from NUM_REQ-1 to 0.
module mem_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int slot;
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block leaves a value held and infers a latch.
        found = 1'b0;
        idx   = '0;
        slot  = 0;
        // Walk from the farthest slot back to rr_ptr so the nearest hit is the
        // last one written and therefore wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            slot = int'(rr_ptr) + i;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (req[slot[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = slot[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port memory.
// One complete write, or read plus data return, per grant; fully registered outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           busy,
    output logic                           mem_valid,
    output logic                           mem_wr_rd,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic                           mem_ready,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [1:0]             lat_cnt_q, lat_cnt_d;

    logic [NUM_REQ-1:0]     gnt_d, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_d, mem_wdata_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic                   busy_d, mem_valid_d, mem_wr_rd_d;

    logic                   found;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       ptr_after_owner;

    mem_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .found   (found),
        .idx     (pick_idx)
    );

    assign ptr_after_owner = IDX_W'(rr_next(int'(owner_q), NUM_REQ));

    // The mem_* output registers double as the latched request fields; they
    // keep the winner's values until the next arbitration.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        lat_cnt_d   = lat_cnt_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata;
        mem_valid_d = mem_valid;
        mem_wr_rd_d = mem_wr_rd;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = ISSUE;
                    owner_d         = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    mem_valid_d     = 1'b1;
                    mem_wr_rd_d     = req_wr_rd[pick_idx];
                    mem_addr_d      = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d     = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (mem_wr_rd == WR) begin
                        state_d  = IDLE;
                        rr_ptr_d = ptr_after_owner;
                    end else begin
                        state_d   = WAIT_RD;
                        lat_cnt_d = 2'(RD_LAT - 1);
                    end
                end
            end
            WAIT_RD: begin
                if (lat_cnt_q == '0) begin
                    rdata_d           = mem_rdata;
                    rvalid_d[owner_q] = 1'b1;
                    state_d           = IDLE;
                    rr_ptr_d          = ptr_after_owner;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            lat_cnt_q <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_valid <= 1'b0;
            mem_wr_rd <= RD;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            gnt       <= gnt_d;
            rvalid    <= rvalid_d;
            rdata     <= rdata_d;
            busy      <= busy_d;
            mem_valid <= mem_valid_d;
            mem_wr_rd <= mem_wr_rd_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that lets NUM_REQ requesters (test agents, scrub engine, DMA) share the single-port memory block.
- Sits between the requesters and the memory's design-side interface. Issues one complete transaction (one write, or one read plus its data return) per grant.
- Serialises all traffic so the memory sees at most one outstanding access.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 6, memory address width.
- DATA_WIDTH, 16, memory data width.
- RD_LAT, 1, cycles from memory accepting a read (mem_valid and mem_ready both high) to mem_rdata being valid (1..4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester request; held with its fields until gnt.
- req_wr_rd  input  NUM_REQ  per-requester access type: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed per-requester address.
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed per-requester write data.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: the request has been captured.
- rvalid  output  NUM_REQ  one-hot, one-cycle pulse: rdata is valid for that requester.
- rdata  output  DATA_WIDTH  read data returned to the owner.
- busy  output  1  high whenever state is not IDLE.
- mem_valid  output  1  transaction valid to the memory.
- mem_wr_rd  output  1  access type to the memory.
- mem_addr  output  ADDR_WIDTH  address to the memory.
- mem_wdata  output  DATA_WIDTH  write data to the memory.
- mem_ready  input  1  memory accepts the transaction this cycle.
- mem_rdata  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE; rr_ptr = 0; lat_cnt = 0.
  - Reset asserted mid-transaction abandons it: no rvalid, no further mem_valid. mem_valid is 0 the cycle after rst is sampled.
- All outputs are registered.
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning upward from rr_ptr, wrapping at NUM_REQ-1 -> 0.
  - The winner's owner index, wr_rd, addr and wdata are latched. Next cycle: state = ISSUE, gnt[owner] = 1 for exactly that cycle.
- ISSUE:
  - mem_valid = 1, driven from the latched fields, and held stable until mem_ready.
  - On mem_ready with a write: next state IDLE, rr_ptr = (owner+1) mod NUM_REQ.
  - On mem_ready with a read: next state WAIT_RD, lat_cnt = RD_LAT-1.
- WAIT_RD:
  - mem_valid = 0. lat_cnt decrements each cycle.
  - At lat_cnt = 0: mem_rdata is captured into rdata and rvalid[owner] = 1 next cycle; state = IDLE; rr_ptr = (owner+1) mod NUM_REQ.
  - rdata holds its value until the next read return.
- Latency with mem_ready tied high:
  - Write: gnt at T+1 and memory write at T+1, where T is the IDLE cycle req is sampled; back in IDLE at T+2.
  - Read: rvalid at T+2+RD_LAT.
- Throughput: a new arbitration happens only in IDLE, so at most one transaction per 2 cycles for writes and per 2+RD_LAT cycles for reads.
- Requester rules:
  - req may drop the cycle after gnt. Holding req high requests a new transaction.
  - Fields sampled only in the IDLE arbitration cycle; later changes are ignored.
- Fairness: a continuously requesting requester is served within NUM_REQ transactions. The owner is never granted twice in a row while another req is pending.
- Simultaneous events:
  - req changes during ISSUE or WAIT_RD have no effect.
  - req and rst in the same cycle: reset wins.
- mem_ready stuck low: stay in ISSUE indefinitely, busy = 1, no timeout.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum state_t {IDLE, ISSUE, WAIT_RD};
  - localparams WR = 1'b1, RD = 1'b0;
  - function for the rr_ptr wrap.
- One sub-module, mem_rr_picker: combinational rotate-priority encoder. Inputs req and rr_ptr; outputs found and idx. Parameterised by NUM_REQ.

Test Plan:
1. Single write: req=4'b0001, wr_rd=1, addr=6'h0A, wdata=16'hBEEF, mem_ready=1 -> gnt=0001 one cycle later; one mem_valid cycle with addr 0x0A, data 0xBEEF; busy low after 2 cycles.
2. Write then read, RD_LAT=1: write 0x1234 to addr 0x05 from req 2, then read addr 0x05 from req 3 -> rvalid=1000 with rdata=0x1234 exactly 3 cycles after the read's arbitration cycle.
3. Round-robin: all four req held high, all writes -> gnt order 0,1,2,3,0,1 on consecutive arbitrations; never the same requester twice in a row.
4. Backpressure: mem_ready=0 for 5 cycles during ISSUE -> mem_valid, addr and wdata stable for 6 cycles, then one accept; no extra gnt.
5. Reset mid-read: rst asserted in the WAIT_RD cycle -> no rvalid; all outputs 0 the next cycle; the next arbitration starts from rr_ptr=0.
6. RD_LAT=3 with req 1 reading while req 0 waits -> req 0's gnt does not appear until the cycle after rvalid[1].
